// File: rtl/des_select_sequencer_if.sv
// Reconfiguration request and multiplexer-control signals of the design-select sequencer.
// The requester side uses the master modport; the sequencer uses the slave modport.
interface des_select_sequencer_if #(
  parameter int SEL_W = 6
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [SEL_W-1:0] cfg_sel;
  logic             cfg_sync;
  logic             cfg_hold;
  logic             cfg_lock;
  logic [SEL_W-1:0] des_sel;
  logic             hold_if_not_sel;
  logic             sync_inputs;
  logic             force_reset;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             locked;

  modport master (
    output cfg_valid, cfg_sel, cfg_sync, cfg_hold, cfg_lock,
    input  cfg_ready, des_sel, hold_if_not_sel, sync_inputs, force_reset,
           busy, done, cfg_err, locked
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_sync, cfg_hold, cfg_lock,
    output cfg_ready, des_sel, hold_if_not_sel, sync_inputs, force_reset,
           busy, done, cfg_err, locked
  );
endinterface

// File: rtl/des_select_sequencer.sv
// Design-select sequencer: quiesce, switch select, settle, then release the new design.
// Optional configuration lock enabled by defining DES_SEQ_LOCK_EN.
//
//   state   | meaning
//   RUN     | selected design running, requests accepted
//   QUIESCE | current design held in reset, old select still applied
//   SETTLE  | new select applied, decode register and 3FF synchronisers flushing
//   RELEASE | new design held in reset before release
module des_select_sequencer #(
  parameter int NUM_DES        = 64,
  parameter int SEL_W          = 6,
  parameter int DEFAULT_SEL    = 0,
  parameter int QUIESCE_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int RESET_CYCLES   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  des_select_sequencer_if.slave bus
);

  localparam int CNT_MAX_QS = (QUIESCE_CYCLES > SETTLE_CYCLES) ? QUIESCE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_QS > RESET_CYCLES) ? CNT_MAX_QS : RESET_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  generate
    if ((1 << SEL_W) < NUM_DES) begin : g_sel_w_chk
      $error("des_select_sequencer: SEL_W too narrow for NUM_DES");
    end
    if (QUIESCE_CYCLES < 1 || SETTLE_CYCLES < 1 || RESET_CYCLES < 1) begin : g_cyc_chk
      $error("des_select_sequencer: phase lengths must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    QUIESCE = 2'd1,
    SETTLE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sync_q, sync_d;
  logic               hold_q, hold_d;
  logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
  logic               pend_sync_q, pend_sync_d;
  logic               pend_hold_q, pend_hold_d;
  logic               ready_q, ready_d;
  logic               force_q, force_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               locked_q, locked_d;

  logic               handshake;
  logic               sel_ok;
  logic [31:0]        sel_ext;

`ifdef DES_SEQ_LOCK_EN
  logic               pend_lock_q, pend_lock_d;
`else
  logic               unused_lock;
  assign unused_lock = bus.cfg_lock;
`endif

  assign sel_ext   = 32'(bus.cfg_sel);
  assign sel_ok    = sel_ext < 32'(NUM_DES);
  assign handshake = bus.cfg_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    sync_d      = sync_q;
    hold_d      = hold_q;
    pend_sel_d  = pend_sel_q;
    pend_sync_d = pend_sync_q;
    pend_hold_d = pend_hold_q;
    locked_d    = locked_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef DES_SEQ_LOCK_EN
    pend_lock_d = pend_lock_q;
`endif

    case (state_q)
      RUN: begin
        if (handshake) begin
          if (sel_ok) begin
            state_d     = QUIESCE;
            cnt_d       = CNT_W'(QUIESCE_CYCLES - 1);
            pend_sel_d  = bus.cfg_sel;
            pend_sync_d = bus.cfg_sync;
            pend_hold_d = bus.cfg_hold;
`ifdef DES_SEQ_LOCK_EN
            pend_lock_d = bus.cfg_lock;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      QUIESCE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          sel_d   = pend_sel_q;
          sync_d  = pend_sync_q;
          hold_d  = pend_hold_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
          cnt_d   = CNT_W'(RESET_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          done_d  = 1'b1;
`ifdef DES_SEQ_LOCK_EN
          // post-reset release has pend_lock cleared, so only a real request locks
          locked_d = locked_q | pend_lock_q;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RELEASE;
    endcase

`ifndef DES_SEQ_LOCK_EN
    locked_d = 1'b0;
`endif
    ready_d = (state_d == RUN) && !locked_d;
    force_d = (state_d != RUN);
    busy_d  = (state_d != RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RELEASE;
      cnt_q       <= CNT_W'(RESET_CYCLES - 1);
      sel_q       <= SEL_W'(DEFAULT_SEL);
      sync_q      <= 1'b1;
      hold_q      <= 1'b1;
      pend_sel_q  <= SEL_W'(DEFAULT_SEL);
      pend_sync_q <= 1'b1;
      pend_hold_q <= 1'b1;
      ready_q     <= 1'b0;
      force_q     <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
`ifdef DES_SEQ_LOCK_EN
      pend_lock_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      sync_q      <= sync_d;
      hold_q      <= hold_d;
      pend_sel_q  <= pend_sel_d;
      pend_sync_q <= pend_sync_d;
      pend_hold_q <= pend_hold_d;
      ready_q     <= ready_d;
      force_q     <= force_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
`ifdef DES_SEQ_LOCK_EN
      pend_lock_q <= pend_lock_d;
`endif
    end
  end

  assign bus.cfg_ready       = ready_q;
  assign bus.des_sel         = sel_q;
  assign bus.sync_inputs     = sync_q;
  assign bus.hold_if_not_sel = hold_q;
  assign bus.force_reset     = force_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.cfg_err         = err_q;
  assign bus.locked          = locked_q;

endmodule

// File: tb/tb_des_select_sequencer.sv
// Self-checking bench for des_select_sequencer: timestamp-based reference model,
// directed vector table, corner-case sequences and randomized requests.
module tb_des_select_sequencer;

  localparam int Q = 4;
  localparam int S = 4;
  localparam int R = 8;
  localparam int NUMD = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  des_select_sequencer_if #(.SEL_W(6)) bus ();
  des_select_sequencer_if #(.SEL_W(6)) bus4 ();

  des_select_sequencer #(
    .NUM_DES(NUMD), .SEL_W(6), .DEFAULT_SEL(0),
    .QUIESCE_CYCLES(Q), .SETTLE_CYCLES(S), .RESET_CYCLES(R)
  ) dut (
    .clock(clk), .reset_n(rst_n), .bus(bus.slave)
  );

  des_select_sequencer #(
    .NUM_DES(4), .SEL_W(6), .DEFAULT_SEL(0),
    .QUIESCE_CYCLES(Q), .SETTLE_CYCLES(S), .RESET_CYCLES(R)
  ) dut4 (
    .clock(clk), .reset_n(rst_n), .bus(bus4.slave)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: every effect of a request is a timestamp on the cycle counter
  int         cyc = 0;
  int         run_at = 0;
  int         switch_at = -1;
  int         err_at = -1;
  int         hs_cyc = -1;
  bit         hs_flag = 0;
  bit         in_reset = 1;
  bit         exp_ready = 0;
  bit         m_locked = 0;
  bit         pend_lock = 0;
  logic [5:0] cur_sel = 6'd0, pend_sel = 6'd0;
  bit         cur_sync = 1, cur_hold = 1, pend_sync = 1, pend_hold = 1;

  typedef struct {
    logic [5:0] sel;
    bit         sync;
    bit         hold;
    int         exp_lat;
    logic [5:0] exp_sel;
    bit         exp_sync;
    bit         exp_hold;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s cycle=%0d actual=timeout required=event", name, cyc);
  endtask

  task automatic check_reset_vals();
    chk("rst_des_sel", 32'(bus.des_sel), 0);
    chk("rst_hold", 32'(bus.hold_if_not_sel), 1);
    chk("rst_sync", 32'(bus.sync_inputs), 1);
    chk("rst_force", 32'(bus.force_reset), 1);
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_ready", 32'(bus.cfg_ready), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.cfg_err), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    exp_ready = 0;
  endtask

  task automatic step();
    bit exp_busy, exp_done;
    hs_flag = 0;
    if (!in_reset && exp_ready && bus.cfg_valid) begin
      hs_flag = 1;
      hs_cyc  = cyc;
      if (int'(bus.cfg_sel) < NUMD) begin
        switch_at = cyc + Q + 1;
        run_at    = cyc + Q + S + R + 1;
        pend_sel  = bus.cfg_sel;
        pend_sync = bus.cfg_sync;
        pend_hold = bus.cfg_hold;
        pend_lock = bus.cfg_lock;
      end else begin
        err_at = cyc + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (in_reset) begin
      check_reset_vals();
    end else begin
      if (cyc == switch_at) begin
        cur_sel  = pend_sel;
        cur_sync = pend_sync;
        cur_hold = pend_hold;
      end
`ifdef DES_SEQ_LOCK_EN
      if (cyc == run_at && pend_lock) m_locked = 1;
`endif
      exp_busy  = (cyc < run_at);
      exp_done  = (cyc == run_at);
      exp_ready = !exp_busy && !m_locked;
      chk("des_sel", 32'(bus.des_sel), 32'(cur_sel));
      chk("sync_inputs", 32'(bus.sync_inputs), 32'(cur_sync));
      chk("hold_if_not_sel", 32'(bus.hold_if_not_sel), 32'(cur_hold));
      chk("force_reset", 32'(bus.force_reset), 32'(exp_busy));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("cfg_ready", 32'(bus.cfg_ready), 32'(exp_ready));
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("cfg_err", 32'(bus.cfg_err), 32'(cyc == err_at));
      chk("locked", 32'(bus.locked), 32'(m_locked));
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    in_reset = 1;
    check_reset_vals();
    repeat (n) step();
    rst_n     = 1'b1;
    in_reset  = 0;
    cur_sel   = 6'd0;
    cur_sync  = 1;
    cur_hold  = 1;
    switch_at = -1;
    err_at    = -1;
    pend_lock = 0;
    m_locked  = 0;
    exp_ready = 0;
    run_at    = cyc + R;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc < run_at && n < 100) begin
      step();
      n++;
    end
    if (cyc < run_at) bound_fail("wait_idle_bound");
  endtask

  task automatic request(input logic [5:0] sel, input bit sync, input bit hold,
                         input bit lock, output int t);
    int n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_sync  = sync;
    bus.cfg_hold  = hold;
    bus.cfg_lock  = lock;
    hs_flag = 0;
    while (!hs_flag && n < 100) begin
      step();
      n++;
    end
    bus.cfg_valid = 1'b0;
    t = hs_cyc;
    if (!hs_flag) bound_fail("request_bound");
  endtask

  initial begin
    int t, t1, t2, c0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_sel    = 6'd0;
    bus.cfg_sync   = 1'b0;
    bus.cfg_hold   = 1'b0;
    bus.cfg_lock   = 1'b0;
    bus4.cfg_valid = 1'b0;
    bus4.cfg_sel   = 6'd0;
    bus4.cfg_sync  = 1'b0;
    bus4.cfg_hold  = 1'b0;
    bus4.cfg_lock  = 1'b0;

    tbl[0] = '{sel: 6'd37, sync: 0, hold: 1, exp_lat: 17, exp_sel: 6'd37, exp_sync: 0, exp_hold: 1};
    tbl[1] = '{sel: 6'd63, sync: 1, hold: 0, exp_lat: 17, exp_sel: 6'd63, exp_sync: 1, exp_hold: 0};
    tbl[2] = '{sel: 6'd0,  sync: 1, hold: 1, exp_lat: 17, exp_sel: 6'd0,  exp_sync: 1, exp_hold: 1};
    tbl[3] = '{sel: 6'd0,  sync: 1, hold: 1, exp_lat: 17, exp_sel: 6'd0,  exp_sync: 1, exp_hold: 1};
    tbl[4] = '{sel: 6'd21, sync: 0, hold: 0, exp_lat: 17, exp_sel: 6'd21, exp_sync: 0, exp_hold: 0};

    #2;
    do_reset(3);
    c0 = cyc;
    wait_idle();
    chk("post_reset_release_len", 32'(cyc - c0), R);
    chk("post_reset_done", 32'(bus.done), 1);

    for (int i = 0; i < 5; i++) begin
      wait_idle();
      request(tbl[i].sel, tbl[i].sync, tbl[i].hold, 1'b0, t);
      while (cyc < t + Q) step();
      chk("sel_before_switch", 32'(bus.des_sel == tbl[i].exp_sel && i != 3 && i != 2), 0);
      step();
      chk("sel_switch", 32'(bus.des_sel), 32'(tbl[i].exp_sel));
      wait_idle();
      chk("latency", 32'(cyc - t), 32'(tbl[i].exp_lat));
      chk("done_end", 32'(bus.done), 1);
      chk("sync_end", 32'(bus.sync_inputs), 32'(tbl[i].exp_sync));
      chk("hold_end", 32'(bus.hold_if_not_sel), 32'(tbl[i].exp_hold));
    end

    // out-of-range selects on the NUM_DES=4 instance
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      bus4.cfg_valid = 1'b1;
      bus4.cfg_sel   = (k == 0) ? 6'd5 : 6'd4;
      step();
      bus4.cfg_valid = 1'b0;
      chk("d4_err_pulse", 32'(bus4.cfg_err), 1);
      chk("d4_des_sel", 32'(bus4.des_sel), 0);
      chk("d4_force", 32'(bus4.force_reset), 0);
      chk("d4_ready", 32'(bus4.cfg_ready), 1);
      chk("d4_busy", 32'(bus4.busy), 0);
      chk("d4_no_done", 32'(bus4.done), 0);
      step();
      chk("d4_err_clear", 32'(bus4.cfg_err), 0);
    end
    bus4.cfg_valid = 1'b1;
    bus4.cfg_sel   = 6'd3;
    step();
    bus4.cfg_valid = 1'b0;
    chk("d4_accept_busy", 32'(bus4.busy), 1);
    chk("d4_accept_no_err", 32'(bus4.cfg_err), 0);

    // request held through a running sequence is taken on the first ready cycle
    wait_idle();
    request(6'd20, 1'b0, 1'b1, 1'b0, t1);
    request(6'd9, 1'b1, 1'b0, 1'b0, t2);
    chk("held_accept_cycle", 32'(t2 - t1), 17);
    wait_idle();
    chk("held_sel", 32'(bus.des_sel), 9);

    // reset during SETTLE discards the new design and restarts the release phase
    request(6'd12, 1'b1, 1'b0, 1'b0, t);
    while (cyc < t + Q + 2) step();
    chk("settle_sel", 32'(bus.des_sel), 12);
    do_reset(2);
    c0 = cyc;
    wait_idle();
    chk("rerelease_len", 32'(cyc - c0), R);
    chk("rerelease_sel", 32'(bus.des_sel), 0);

    // randomized requests
    for (int n = 0; n < 800; n++) begin
      if (!bus.cfg_valid && $urandom_range(0, 3) == 0) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_sel   = 6'($urandom_range(0, 63));
        bus.cfg_sync  = 1'($urandom_range(0, 1));
        bus.cfg_hold  = 1'($urandom_range(0, 1));
        bus.cfg_lock  = 1'b0;
      end
      step();
      if (hs_flag) bus.cfg_valid = 1'b0;
    end
    bus.cfg_valid = 1'b0;
    wait_idle();

`ifdef DES_SEQ_LOCK_EN
    request(6'd3, 1'b1, 1'b1, 1'b1, t);
    wait_idle();
    chk("lock_set", 32'(bus.locked), 1);
    chk("lock_done", 32'(bus.done), 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_sel   = 6'd7;
    bus.cfg_lock  = 1'b0;
    hs_flag = 0;
    for (int n = 0; n < 30; n++) step();
    chk("lock_block_ready", 32'(bus.cfg_ready), 0);
    chk("lock_block_sel", 32'(bus.des_sel), 3);
    bus.cfg_valid = 1'b0;
    do_reset(2);
    wait_idle();
    chk("lock_cleared", 32'(bus.locked), 0);
    request(6'd7, 1'b0, 1'b0, 1'b0, t);
    wait_idle();
    chk("after_unlock_sel", 32'(bus.des_sel), 7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_select_sequencer.md
Name: des_select_sequencer

Overview:
Controls the design-select multiplexer. Accepts reconfiguration requests over a valid/ready handshake and drives des_sel, hold_if_not_sel and sync_inputs. It also drives force_reset, which is ORed into the multiplexer's reset input. Every switch follows a fixed sequence: quiesce the current design, switch the select, let the decode register and 3-flop input synchronisers settle, then release the new design from reset. No design ever runs while the select or input path is changing.

Parameters:
NUM_DES, 64, number of designs; requests with cfg_sel >= NUM_DES are rejected
SEL_W, 6, select width; elaboration error if 2**SEL_W < NUM_DES
DEFAULT_SEL, 0, design selected out of reset
QUIESCE_CYCLES, 4, cycles of forced reset before switching (>=1)
SETTLE_CYCLES, 4, cycles after switch for decode register plus 3FF flush (>=1)
RESET_CYCLES, 8, cycles of forced reset on the new design before release (>=1)

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  request valid
cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
cfg_sel  in  SEL_W  requested design
cfg_sync  in  1  requested sync_inputs value
cfg_hold  in  1  requested hold_if_not_sel value
cfg_lock  in  1  lock request (optional feature only)
des_sel  out  SEL_W  to multiplexer
hold_if_not_sel  out  1  to multiplexer
sync_inputs  out  1  to multiplexer
force_reset  out  1  ORed into multiplexer reset
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when the new design is released
cfg_err  out  1  one-cycle pulse when a request is rejected
locked  out  1  configuration locked (optional feature only)

Behaviour:
- All outputs are registered.
- States: RUN, QUIESCE, SETTLE, RELEASE. A single down-counter is loaded on each state entry.
- Reset values while reset_n=0:
  - state=RELEASE, counter=RESET_CYCLES-1.
  - des_sel=DEFAULT_SEL, hold_if_not_sel=1, sync_inputs=1, force_reset=1, busy=1.
  - cfg_ready=0, done=0, cfg_err=0, locked=0.
- RUN:
  - cfg_ready=1, force_reset=0, busy=0.
  - A handshake with cfg_sel < NUM_DES captures sel, sync and hold, then goes to QUIESCE.
  - A handshake with cfg_sel >= NUM_DES pulses cfg_err the next cycle and stays in RUN; outputs are unchanged.
  - A request equal to the current config still runs the full sequence (re-reset).
- QUIESCE: force_reset=1, busy=1, cfg_ready=0, lasting QUIESCE_CYCLES cycles. des_sel, sync_inputs and hold_if_not_sel keep their old values.
- Leaving QUIESCE: des_sel, sync_inputs and hold_if_not_sel load the captured values on the same edge that enters SETTLE.
- SETTLE: force_reset=1 for SETTLE_CYCLES cycles, then RELEASE.
- RELEASE: force_reset=1 for RESET_CYCLES cycles, then RUN with done=1 for exactly one cycle.
- Latency: handshake accepted in cycle T gives:
  - new des_sel visible from T+QUIESCE_CYCLES+1;
  - force_reset=0, cfg_ready=1 and done=1 from T+Q+S+R+1.
  - Defaults give 17 cycles.
- Post-reset release: the first RUN cycle is RESET_CYCLES cycles after reset_n rises, with done=1. des_sel=DEFAULT_SEL throughout.
- cfg_valid while busy is ignored; no capture, no error. The requester holds cfg_valid until accepted.
- Asserting reset_n mid-sequence aborts immediately to reset values. A captured but not yet applied request is discarded.
- done and cfg_err are never asserted in the same cycle.

Optional Feature:
- Macro DES_SEQ_LOCK_EN.
- Defined:
  - An accepted, valid request with cfg_lock=1 sets locked when the sequence completes (same cycle as done).
  - While locked=1, cfg_ready stays 0 and all requests are ignored. Only reset_n clears locked.
  - A rejected request never sets locked.
- Undefined: cfg_lock is ignored and locked is tied to 0.

Test Plan:
- Release reset -> force_reset=1 for 8 cycles, des_sel=0, then done pulse, cfg_ready=1, busy=0.
- In RUN, request sel=37, sync=0, hold=1 -> des_sel=37 exactly 5 cycles after handshake; force_reset high for cycles 1..16; done at cycle 17; sync_inputs=0.
- Request sel=5 with NUM_DES=4 (parameter override) -> cfg_err pulse next cycle, no state change, des_sel unchanged, force_reset stays 0.
- Hold cfg_valid with sel=9 during a sequence -> no capture until RUN; then sel=9 is accepted on the first cfg_ready cycle and the full sequence runs.
- Assert reset_n in SETTLE after switching to sel=12 -> des_sel=0 and force_reset=1 immediately; after release, the 8-cycle RELEASE sequence runs again.
- With DES_SEQ_LOCK_EN, request sel=3, lock=1 -> locked=1 with done; the following request sel=7 is never accepted (cfg_ready=0) until reset_n.
